// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding 32-bit bus read, valid/ready delivery
// to the decoder, redirect handling and fault reporting with halt-until-redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_pc_load,
  input  logic [31:0] I_next_pc,
  input  logic        I_dec_ready,
  output logic        O_bus_req,
  output logic [31:0] O_bus_addr,
  input  logic        I_bus_ack,
  input  logic [31:0] I_bus_data,
  input  logic        I_bus_err,
  output logic        O_valid,
  output logic [31:0] O_instr,
  output logic [31:0] O_pc,
  output logic        O_fault,
  output logic [1:0]  O_fault_cause
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {REQ, WAIT, HOLD, HALT} state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic        r_kill, w_kill_next;
  logic        r_bus_req;
  logic [31:0] r_bus_addr, w_bus_addr_next;
  logic        r_valid;
  logic [31:0] r_instr, w_instr_next;
  logic [31:0] r_opc, w_opc_next;
  logic        r_fault, w_fault_next;
  logic [1:0]  r_cause, w_cause_next;

  // Request and valid are registered decodes of the next state so both are glitch-free.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_state    <= REQ;
      r_pc       <= RESET_PC;
      r_kill     <= 1'b0;
      r_bus_req  <= 1'b0;
      r_bus_addr <= 32'h0;
      r_valid    <= 1'b0;
      r_instr    <= NOP;
      r_opc      <= 32'h0;
      r_fault    <= 1'b0;
      r_cause    <= 2'b00;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_kill     <= w_kill_next;
      r_bus_req  <= (w_state_next == WAIT);
      r_bus_addr <= w_bus_addr_next;
      r_valid    <= (w_state_next == HOLD);
      r_instr    <= w_instr_next;
      r_opc      <= w_opc_next;
      r_fault    <= w_fault_next;
      r_cause    <= w_cause_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_kill_next     = r_kill;
    w_bus_addr_next = r_bus_addr;
    w_instr_next    = r_instr;
    w_opc_next      = r_opc;
    w_fault_next    = r_fault;
    w_cause_next    = r_cause;

    case (r_state)
      REQ: begin
        if (I_pc_load) begin
          w_pc_next = I_next_pc;
        end else if (r_pc[1:0] != 2'b00) begin
          w_instr_next = NOP;
          w_opc_next   = r_pc;
          w_fault_next = 1'b1;
          w_cause_next = 2'b01;
          w_state_next = HOLD;
        end else begin
          w_bus_addr_next = r_pc;
          w_state_next    = WAIT;
        end
      end

      // A redirect never aborts the bus cycle; it marks the response as stale instead.
      WAIT: begin
        if (I_bus_ack) begin
          w_kill_next = 1'b0;
          if (I_pc_load || r_kill) begin
            w_state_next = REQ;
            if (I_pc_load) w_pc_next = I_next_pc;
          end else begin
            w_opc_next   = r_bus_addr;
            w_fault_next = I_bus_err;
            w_cause_next = I_bus_err ? 2'b10 : 2'b00;
            w_instr_next = I_bus_err ? NOP : I_bus_data;
            w_state_next = HOLD;
          end
        end else if (I_pc_load) begin
          w_pc_next   = I_next_pc;
          w_kill_next = 1'b1;
        end
      end

      HOLD: begin
        if (I_pc_load) begin
          w_pc_next    = I_next_pc;
          w_state_next = REQ;
        end else if (I_dec_ready) begin
          if (r_fault) begin
            w_state_next = HALT;
          end else begin
            w_pc_next    = r_pc + 32'd4;
            w_state_next = REQ;
          end
        end
      end

      HALT: begin
        if (I_pc_load) begin
          w_pc_next    = I_next_pc;
          w_state_next = REQ;
        end
      end

      default: w_state_next = REQ;
    endcase
  end

  assign O_bus_req     = r_bus_req;
  assign O_bus_addr    = r_bus_addr;
  assign O_valid       = r_valid;
  assign O_instr       = r_instr;
  assign O_pc          = r_opc;
  assign O_fault       = r_fault;
  assign O_fault_cause = r_cause;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: transaction-level fetch model feeding a scoreboard
// queue, with an independent monitor checking delivered items and bus requests.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
    logic [1:0]  cause;
    int          epoch;
  } item_t;

  logic        I_clk, I_reset, I_pc_load, I_dec_ready, I_bus_ack, I_bus_err;
  logic [31:0] I_next_pc, I_bus_data;
  logic        O_bus_req, O_valid, O_fault;
  logic [31:0] O_bus_addr, O_instr, O_pc;
  logic [1:0]  O_fault_cause;

  // Reference model state: what the next fetch should be and which read is in flight.
  item_t       expQ[$];
  int          epoch = 0;
  bit          pending = 1'b0;
  logic [31:0] expAddr = RESET_PC;
  bit          outstanding = 1'b0;
  bit          killed = 1'b0;
  logic [31:0] reqAddr = 32'h0;

  // Bus responder and stimulus knobs.
  int waitMin = 2, waitMax = 2, waitCnt = 0, waitTarget = 2;
  int readyPct = 100, spurPct = 0, missed = 0;
  bit done = 1'b0;

  // Monitor-owned flags handed to the model each cycle.
  bit          sawNewReq = 1'b0, xferFlag = 1'b0, xferFault = 1'b0;
  logic [31:0] xferPc = 32'h0;
  bit          prevReq = 1'b0, prevReset = 1'b0;
  int          stallAge = 0;
  int          vectors = 0, miscompares = 0;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .I_clk(I_clk), .I_reset(I_reset), .I_pc_load(I_pc_load), .I_next_pc(I_next_pc),
    .I_dec_ready(I_dec_ready), .O_bus_req(O_bus_req), .O_bus_addr(O_bus_addr),
    .I_bus_ack(I_bus_ack), .I_bus_data(I_bus_data), .I_bus_err(I_bus_err),
    .O_valid(O_valid), .O_instr(O_instr), .O_pc(O_pc), .O_fault(O_fault),
    .O_fault_cause(O_fault_cause)
  );

  initial begin
    I_clk = 1'b0;
    forever #5 I_clk = ~I_clk;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic errAt(input logic [31:0] a);
    return (a[11:8] == 4'h3) && (a[3:2] == 2'b00);
  endfunction

  function automatic item_t mkItem(input logic [31:0] pc, input logic [31:0] instr,
                                   input logic fault, input logic [1:0] cause, input int ep);
    item_t it;
    it.pc = pc; it.instr = instr; it.fault = fault; it.cause = cause; it.epoch = ep;
    return it;
  endfunction

  // kind: 0 idle, 1 redirect, 2 redirect only while a request is visible,
  //       3 reset, 4 reset only while a request is visible.
  task automatic applyStimulus(input int kind, input logic [31:0] target, output bit fired);
    bit doLoad, doRst, ack;
    @(negedge I_clk);
    doLoad = (kind == 1) || (kind == 2 && O_bus_req);
    doRst  = (kind == 3) || (kind == 4 && O_bus_req);
    fired  = doLoad || doRst;
    if (O_bus_req) begin
      if (waitCnt >= waitTarget) begin
        ack        = 1'b1;
        I_bus_data = memData(O_bus_addr);
        I_bus_err  = errAt(O_bus_addr);
        waitCnt    = 0;
        waitTarget = $urandom_range(waitMax, waitMin);
      end else begin
        ack        = 1'b0;
        waitCnt++;
        I_bus_data = $urandom;
        I_bus_err  = 1'($urandom_range(1, 0));
      end
    end else begin
      waitCnt    = 0;
      ack        = ($urandom_range(99, 0) < spurPct);
      I_bus_data = $urandom;
      I_bus_err  = 1'($urandom_range(1, 0));
    end
    I_bus_ack   = ack;
    I_pc_load   = doLoad;
    I_next_pc   = doLoad ? target : $urandom;
    I_reset     = doRst;
    I_dec_ready = ($urandom_range(99, 0) < readyPct);
    #2;
    if (doRst) begin
      epoch++;
      pending = 1'b1; expAddr = RESET_PC; outstanding = 1'b0; killed = 1'b0;
    end else begin
      if (xferFlag && !xferFault) begin
        pending = 1'b1; expAddr = xferPc + 32'd4;
      end
      if (sawNewReq) begin
        outstanding = 1'b1; reqAddr = expAddr; killed = 1'b0; pending = 1'b0;
      end
      if (ack && outstanding) begin
        if (!killed && !doLoad) begin
          if (errAt(reqAddr)) expQ.push_back(mkItem(reqAddr, NOP, 1'b1, 2'b10, epoch));
          else                expQ.push_back(mkItem(reqAddr, memData(reqAddr), 1'b0, 2'b00, epoch));
        end
        outstanding = 1'b0; killed = 1'b0;
      end
      if (doLoad) begin
        epoch++;
        if (outstanding) killed = 1'b1;
        if (target[1:0] == 2'b00) begin
          pending = 1'b1; expAddr = target;
        end else begin
          pending = 1'b0;
          expQ.push_back(mkItem(target, NOP, 1'b1, 2'b01, epoch));
        end
      end
    end
  endtask

  task automatic runCycles(input int n);
    bit f;
    for (int i = 0; i < n; i++) applyStimulus(0, 32'h0, f);
  endtask

  task automatic untilFired(input int kind, input logic [31:0] target);
    bit f;
    f = 1'b0;
    for (int i = 0; i < 40 && !f; i++) applyStimulus(kind, target, f);
    if (!f) missed++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    item_t it;
    sawNewReq = 1'b0;
    xferFlag  = 1'b0;
    while (expQ.size() > 0 && expQ[0].epoch != epoch) void'(expQ.pop_front());
    if (prevReset) begin
      check("reset_valid", 32'(O_valid), 32'h0);
      check("reset_bus_req", 32'(O_bus_req), 32'h0);
      check("reset_bus_addr", O_bus_addr, 32'h0);
      check("reset_instr", O_instr, NOP);
      check("reset_pc", O_pc, 32'h0);
      check("reset_fault", 32'(O_fault), 32'h0);
      check("reset_cause", 32'(O_fault_cause), 32'h0);
    end
    if (O_valid) begin
      check("single_outstanding", 32'(O_bus_req), 32'h0);
      if (expQ.size() == 0) begin
        check("unexpected_valid", 32'(O_valid), 32'h0);
      end else begin
        it = expQ[0];
        check("item_pc", O_pc, it.pc);
        check("item_instr", O_instr, it.instr);
        check("item_fault", 32'(O_fault), 32'(it.fault));
        check("item_cause", 32'(O_fault_cause), 32'(it.cause));
        if (I_dec_ready && !I_reset) begin
          xferFlag  = 1'b1;
          xferPc    = it.pc;
          xferFault = it.fault;
          void'(expQ.pop_front());
        end
      end
    end
    if (O_bus_req && !prevReq) begin
      sawNewReq = 1'b1;
      check("req_allowed", 32'(pending && !outstanding), 32'h1);
      check("req_addr", O_bus_addr, expAddr);
    end else if (O_bus_req && outstanding) begin
      check("req_addr_hold", O_bus_addr, reqAddr);
    end
    if (!I_reset && !I_pc_load && !O_valid && !outstanding && !sawNewReq &&
        (pending || expQ.size() > 0)) stallAge++;
    else stallAge = 0;
    if (stallAge >= 3) begin
      check("progress_stall_cycles", 32'(stallAge), 32'h2);
      stallAge = 0;
    end
    prevReq   = O_bus_req;
    prevReset = I_reset;
  endtask

  initial begin
    while (!done) begin
      @(negedge I_clk);
      #1;
      checkOutput();
    end
    while (expQ.size() > 0 && expQ[0].epoch != epoch) void'(expQ.pop_front());
    check("undelivered_items", 32'(expQ.size()), 32'h0);
    check("directed_events_missed", 32'(missed), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    bit f;
    int r, kind;
    logic [31:0] t;
    I_reset = 1'b1; I_pc_load = 1'b0; I_next_pc = 32'h0; I_dec_ready = 1'b0;
    I_bus_ack = 1'b0; I_bus_data = 32'h0; I_bus_err = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(3, 32'h0, f);

    $display("[TB] sequential fetch from reset, two wait states");
    runCycles(15);
    $display("[TB] decoder backpressure");
    readyPct = 0;   runCycles(8);
    readyPct = 100; runCycles(10);
    $display("[TB] redirect to 0x200 while a read is in flight");
    waitMin = 3; waitMax = 3;
    untilFired(2, 32'h0000_0200);
    runCycles(15);
    $display("[TB] misaligned redirect");
    waitMin = 1; waitMax = 1;
    untilFired(1, 32'h0000_0202);
    runCycles(10);
    $display("[TB] bus error then recovery");
    untilFired(1, 32'h0000_0300);
    runCycles(12);
    untilFired(1, 32'h0000_0400);
    runCycles(10);
    $display("[TB] address wrap");
    waitMin = 0; waitMax = 0;
    untilFired(1, 32'hFFFF_FFF8);
    runCycles(14);
    $display("[TB] redirect colliding with ack");
    untilFired(2, 32'h0000_0500);
    runCycles(8);
    $display("[TB] reset during a read with late acks");
    waitMin = 2; waitMax = 2; spurPct = 50;
    runCycles(4);
    untilFired(4, 32'h0);
    runCycles(12);

    $display("[TB] random traffic");
    waitMin = 0; waitMax = 3; spurPct = 10; readyPct = 70;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(999, 0);
      kind = (r < 5) ? 3 : (r < 45) ? 1 : 0;
      t = $urandom & 32'h0000_0FFC;
      r = $urandom_range(99, 0);
      if (r < 12)      t = t | 32'($urandom_range(3, 1));
      else if (r < 18) t = 32'hFFFF_FFF0 | (t & 32'hC);
      applyStimulus(kind, t, f);
    end
    readyPct = 100; spurPct = 0;
    runCycles(30);
    done = 1'b1;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage. It sits directly upstream of the instruction decoder and keeps one 32-bit bus read in flight at a time. It delivers each fetched word with its PC over a valid/ready handshake, and redirects when branch, jump or trap logic loads a new PC. Misaligned PCs and bus errors are reported as faults instead of instructions, and fetch then halts until the next redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- I_clk  in  1  clock, all state updates on rising edge
- I_reset  in  1  synchronous, active-high reset
- I_pc_load  in  1  redirect strobe; abandons the current fetch
- I_next_pc  in  32  redirect target, sampled when I_pc_load=1
- I_dec_ready  in  1  decoder accepts O_instr this cycle
- O_bus_req  out  1  read request; held until I_bus_ack
- O_bus_addr  out  32  word address of the request; equals the fetch PC
- I_bus_ack  in  1  single-cycle response strobe
- I_bus_data  in  32  read data, valid when I_bus_ack=1
- I_bus_err  in  1  bus error, valid when I_bus_ack=1
- O_valid  out  1  O_instr/O_pc/O_fault are valid
- O_instr  out  32  fetched instruction; 32'h0000_0013 (NOP) when O_fault=1
- O_pc  out  32  PC of the delivered word
- O_fault  out  1  delivered item is a fault, not an instruction
- O_fault_cause  out  2  2'b01 misaligned PC; 2'b10 bus error; 2'b00 no fault

## Operation
- Internal registers:
  - pc (32)
  - state: REQ, WAIT, HOLD, HALT
  - kill (1)
  - instr/pc/fault output registers
- Reset:
  - pc=RESET_PC, state=REQ, kill=0.
  - All outputs are 0, except O_instr=NOP.
- REQ:
  - If pc[1:0]!=0: no bus request. Load a fault output (cause 01, O_pc=pc) and go to HOLD.
  - Otherwise: O_bus_req=1, O_bus_addr=pc, go to WAIT.
- WAIT:
  - O_bus_req stays 1 and O_bus_addr stays stable until I_bus_ack.
  - On ack with kill=0:
    - Latch I_bus_data into O_instr and pc into O_pc.
    - If I_bus_err=1: O_fault=1, cause 10, O_instr=NOP.
    - Go to HOLD.
  - On ack with kill=1: discard the data, clear kill, go to REQ.
- HOLD:
  - O_valid=1; outputs stay stable until transfer.
  - Transfer (I_dec_ready=1) of a non-fault item: pc=pc+4 (mod 2^32), go to REQ.
  - Transfer of a fault item: go to HALT.
- HALT:
  - O_valid=0, O_bus_req=0.
  - The unit waits for I_pc_load.
- Redirect (I_pc_load=1) has priority over every other event:
  - pc=I_next_pc in all states.
  - REQ/HOLD/HALT: drop any held item (O_valid=0 next cycle), go to REQ.
  - WAIT without ack this cycle: set kill and stay in WAIT. A bus transaction is never aborted. The new address is issued after the stale ack.
  - WAIT with ack the same cycle: discard the data, go to REQ.
  - In HOLD, a redirect and I_dec_ready in the same cycle: the transfer still counts for the decoder. The held item is consumed and pc takes I_next_pc, not pc+4.
- Only one bus request is outstanding at any time.

## Timing
- REQ lasts exactly one cycle. O_bus_req rises the cycle after entering REQ and the same cycle WAIT is entered (registered).
- Fetch latency:
  - First O_bus_req is asserted 1 cycle after I_reset deasserts.
  - An ack in cycle N gives O_valid=1 in cycle N+1.
  - With zero-wait ack and I_dec_ready tied high, throughput is 1 instruction per 3 cycles (REQ, WAIT, HOLD).
- Misaligned fault: O_valid=1 two cycles after the redirect; no bus activity.
- Mid-operation reset overrides all state. Any outstanding ack arriving after reset is ignored: state is REQ, and a stale ack in REQ is ignored.
- An I_bus_ack outside WAIT is ignored.

## Test plan
- Reset with RESET_PC=0x100, bus ack after 2 wait cycles, I_dec_ready=1:
  - Required: O_bus_addr sequence 0x100, 0x104, 0x108.
  - Required: each O_valid carries the matching O_pc; O_fault=0.
- Backpressure: hold I_dec_ready=0 for 5 cycles with an item valid.
  - Required: O_instr/O_pc stable, O_bus_req=0, no pc increment.
  - On release: next address is O_pc+4.
- Redirect in WAIT: I_pc_load=1 with I_next_pc=0x200 two cycles before ack of 0x104.
  - Required: stale data never appears on O_valid.
  - Required: the next request is 0x200 and the next delivered O_pc is 0x200.
- Misaligned redirect: I_next_pc=0x202.
  - Required: no O_bus_req.
  - Required: O_valid=1 with O_fault=1, cause 01, O_pc=0x202, O_instr=0x00000013.
  - Required: after transfer the unit stays idle until the next I_pc_load.
- Bus error on 0x300:
  - Required: O_fault=1, cause 10, O_pc=0x300.
  - Required: after transfer, no further O_bus_req until a redirect to 0x400, which fetches 0x400.
- Wrap and collisions:
  - pc=0xFFFF_FFFC: after transfer, the next request is 0x0000_0000.
  - I_pc_load together with ack in WAIT: data is dropped and the next request uses I_next_pc.
  - I_reset asserted in WAIT: the late ack is ignored and the first request is RESET_PC.
